// File: rtl/can_fault_confinement.sv
// CAN fault confinement: TEC/REC counters, active/passive/bus-off FSM and bus-off recovery.
// Counters and state move one clk after an event pulse. There is no backpressure; events arriving during bus-off are dropped.
module can_fault_confinement #(
  parameter int CNT_W         = 9,
  parameter int TX_ERR_INC    = 8,
  parameter int RX_ERR_INC    = 1,
  parameter int RX_PRIM_INC   = 8,
  parameter int WARN_LIMIT    = 96,
  parameter int PASSIVE_LIMIT = 128,
  parameter int BUSOFF_LIMIT  = 256,
  parameter int REC_RELOAD    = 120,
  parameter int RECOV_BITS    = 11,
  parameter int RECOV_SEQ     = 128,
  parameter int AUTO_RECOVER  = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sample_point,
  input  logic                               rx_bit,
  input  logic                               tx_err,
  input  logic                               tx_ack_passive_exc,
  input  logic                               tx_success,
  input  logic                               rx_err,
  input  logic                               rx_prim_err,
  input  logic                               rx_success,
  input  logic                               recover_req,
  output logic [CNT_W-1:0]                   tec,
  output logic [CNT_W-1:0]                   rec,
  output logic [1:0]                         err_state,
  output logic                               error_active,
  output logic                               error_passive,
  output logic                               bus_off,
  output logic                               error_warning,
  output logic [$clog2(RECOV_SEQ+1)-1:0]     recov_seq_cnt,
  output logic                               state_chg,
  output logic                               recovered
);
  localparam int BIT_W = $clog2(RECOV_BITS + 1);
  localparam int SEQ_W = $clog2(RECOV_SEQ + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] WARN_L    = CNT_W'(WARN_LIMIT);
  localparam logic [CNT_W-1:0] PASS_L    = CNT_W'(PASSIVE_LIMIT);
  localparam logic [CNT_W-1:0] BO_L      = CNT_W'(BUSOFF_LIMIT);
  localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(REC_RELOAD);
  localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(RECOV_BITS - 1);
  localparam logic [SEQ_W-1:0] SEQ_LAST  = SEQ_W'(RECOV_SEQ - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE     = 2'd0,
    ST_PASSIVE    = 2'd1,
    ST_BUS_OFF    = 2'd2,
    ST_RECOVERING = 2'd3
  } st_e;

  st_e              state, state_nx;
  logic [CNT_W-1:0] tec_nx, rec_nx;
  logic [CNT_W:0]   tec_inc, rec_inc_p, rec_inc_o;
  logic [BIT_W-1:0] bit_cnt;
  logic             rec_ok, bit_done, seq_done, done;

  assign err_state = state;
  assign rec_ok    = recover_req || (AUTO_RECOVER != 0);
  assign bit_done  = sample_point && rx_bit && (bit_cnt == BITS_LAST);
  assign seq_done  = bit_done && (recov_seq_cnt == SEQ_LAST);
  assign done      = (state == ST_RECOVERING) && rec_ok && seq_done;

  // Next counter values; an error pulse always suppresses the matching success decrement.
  always_comb begin
    tec_inc   = {1'b0, tec} + (CNT_W+1)'(TX_ERR_INC);
    rec_inc_p = {1'b0, rec} + (CNT_W+1)'(RX_PRIM_INC);
    rec_inc_o = {1'b0, rec} + (CNT_W+1)'(RX_ERR_INC);
    tec_nx    = tec;
    rec_nx    = rec;
    if (tx_err) begin
      if (!(state == ST_PASSIVE && tx_ack_passive_exc))
        tec_nx = (tec_inc > {1'b0, CNT_MAX}) ? CNT_MAX : tec_inc[CNT_W-1:0];
    end else if (tx_success && tec != '0) begin
      tec_nx = tec - ONE;
    end
    if (rx_prim_err)
      rec_nx = (rec_inc_p > {1'b0, CNT_MAX}) ? CNT_MAX : rec_inc_p[CNT_W-1:0];
    else if (rx_err)
      rec_nx = (rec_inc_o > {1'b0, CNT_MAX}) ? CNT_MAX : rec_inc_o[CNT_W-1:0];
    else if (rx_success) begin
      if (rec >= PASS_L)   rec_nx = RELOAD;
      else if (rec != '0)  rec_nx = rec - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tec <= '0;
      rec <= '0;
    end else if (done) begin
      tec <= '0;
      rec <= '0;
    end else if (!state[1]) begin
      tec <= tec_nx;
      rec <= rec_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt       <= '0;
      recov_seq_cnt <= '0;
    end else if (state != ST_RECOVERING || !rec_ok || done) begin
      bit_cnt       <= '0;
      recov_seq_cnt <= '0;
    end else if (sample_point) begin
      if (!rx_bit) begin
        bit_cnt <= '0;
      end else if (bit_done) begin
        bit_cnt       <= '0;
        recov_seq_cnt <= recov_seq_cnt + SEQ_W'(1);
      end else begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_ACTIVE;
      state_chg <= 1'b0;
      recovered <= 1'b0;
    end else begin
      state     <= state_nx;
      state_chg <= (state_nx != state);
      recovered <= done;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_ACTIVE, ST_PASSIVE: begin
        if (tec_nx >= BO_L)                          state_nx = ST_BUS_OFF;
        else if (tec_nx >= PASS_L || rec_nx >= PASS_L) state_nx = ST_PASSIVE;
        else                                         state_nx = ST_ACTIVE;
      end
      ST_BUS_OFF:    if (rec_ok) state_nx = ST_RECOVERING;
      ST_RECOVERING: begin
        if (!rec_ok)       state_nx = ST_BUS_OFF;
        else if (seq_done) state_nx = ST_ACTIVE;
      end
      default:       state_nx = ST_ACTIVE;
    endcase
  end

  always_comb begin
    error_active  = (state == ST_ACTIVE);
    error_passive = (state == ST_PASSIVE);
    bus_off       = state[1];
    error_warning = !state[1] && (tec >= WARN_L || rec >= WARN_L);
  end
endmodule

// File: tb/tb_can_fault_confinement.sv
// Randomized plus directed bench for can_fault_confinement against an integer reference model.
module tb_can_fault_confinement;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_point = 1'b0, rx_bit = 1'b1;
  logic       tx_err = 1'b0, tx_ack_passive_exc = 1'b0, tx_success = 1'b0;
  logic       rx_err = 1'b0, rx_prim_err = 1'b0, rx_success = 1'b0;
  logic       recover_req = 1'b0;
  logic [8:0] tec, rec;
  logic [1:0] err_state;
  logic       error_active, error_passive, bus_off, error_warning;
  logic [7:0] recov_seq_cnt;
  logic       state_chg, recovered;

  can_fault_confinement dut (
    .clk(clk), .rst(rst), .sample_point(sample_point), .rx_bit(rx_bit),
    .tx_err(tx_err), .tx_ack_passive_exc(tx_ack_passive_exc), .tx_success(tx_success),
    .rx_err(rx_err), .rx_prim_err(rx_prim_err), .rx_success(rx_success),
    .recover_req(recover_req), .tec(tec), .rec(rec), .err_state(err_state),
    .error_active(error_active), .error_passive(error_passive), .bus_off(bus_off),
    .error_warning(error_warning), .recov_seq_cnt(recov_seq_cnt),
    .state_chg(state_chg), .recovered(recovered)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  // Reference model: 0 active, 1 passive, 2 bus-off, 3 recovering.
  int m_tec, m_rec, m_state, m_run, m_seq, m_chg, m_recov;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int sat(input int v);
    return (v > 511) ? 511 : v;
  endfunction

  task automatic model_reset();
    m_tec = 0; m_rec = 0; m_state = 0; m_run = 0; m_seq = 0; m_chg = 0; m_recov = 0;
  endtask

  task automatic model_step();
    int prev;
    prev = m_state;
    m_recov = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_state < 2) begin
      if (tx_err) begin
        if (!(m_state == 1 && tx_ack_passive_exc)) m_tec = sat(m_tec + 8);
      end else if (tx_success && m_tec > 0) m_tec = m_tec - 1;
      if (rx_prim_err)     m_rec = sat(m_rec + 8);
      else if (rx_err)     m_rec = sat(m_rec + 1);
      else if (rx_success) m_rec = (m_rec >= 128) ? 120 : ((m_rec > 0) ? m_rec - 1 : 0);
      if (m_tec >= 256)                    m_state = 2;
      else if (m_tec >= 128 || m_rec >= 128) m_state = 1;
      else                                 m_state = 0;
    end else if (m_state == 2) begin
      m_run = 0; m_seq = 0;
      if (recover_req) m_state = 3;
    end else begin
      if (!recover_req) begin
        m_state = 2; m_run = 0; m_seq = 0;
      end else if (sample_point) begin
        m_run = rx_bit ? m_run + 1 : 0;
        if (m_run == 11) begin
          m_run = 0;
          m_seq = m_seq + 1;
          if (m_seq == 128) begin
            m_seq = 0; m_tec = 0; m_rec = 0; m_state = 0; m_recov = 1;
          end
        end
      end
    end
    m_chg = (m_state != prev) ? 1 : 0;
  endtask

  task automatic compare_all();
    chk("tec", tec, m_tec);
    chk("rec", rec, m_rec);
    chk("err_state", err_state, m_state);
    chk("error_active", error_active, m_state == 0);
    chk("error_passive", error_passive, m_state == 1);
    chk("bus_off", bus_off, m_state >= 2);
    chk("error_warning", error_warning, m_state < 2 && (m_tec >= 96 || m_rec >= 96));
    chk("recov_seq_cnt", recov_seq_cnt, m_seq);
    chk("state_chg", state_chg, m_chg);
    chk("recovered", recovered, m_recov);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    tx_err = 0; tx_ack_passive_exc = 0; tx_success = 0;
    rx_err = 0; rx_prim_err = 0; rx_success = 0; sample_point = 0; rx_bit = 1;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    #2;
    model_reset();
    compare_all();
    cycle();
    rst = 1;
  endtask

  initial begin
    int samples;
    bit got;
    model_reset();
    #3;
    compare_all();
    cycle();
    cycle();
    rst = 1;

    // 16 transmit errors: passive at 128, warning from the 12th.
    for (int i = 0; i < 16; i++) begin
      tx_err = 1; cycle();
      if (i == 10) chk("warn_before_96", error_warning, 0);
      if (i == 11) chk("warn_at_96", error_warning, 1);
    end
    idle();
    chk("tp1_tec", tec, 128);
    chk("tp1_state", err_state, 1);

    tx_err = 1; tx_ack_passive_exc = 1; cycle(); idle();
    chk("ack_exc_tec", tec, 128);
    tx_success = 1; cycle(); idle();
    chk("succ_tec", tec, 127);
    chk("succ_active", err_state, 0);
    chk("succ_chg", state_chg, 1);

    for (int i = 0; i < 16; i++) begin rx_prim_err = 1; cycle(); end
    idle();
    rx_err = 1; cycle(); cycle(); idle();
    chk("rec_130", rec, 130);
    rx_success = 1; cycle(); idle();
    chk("reload_rec", rec, 120);
    chk("reload_active", err_state, 0);
    rx_err = 1; rx_prim_err = 1; cycle(); idle();
    chk("both_rx_rec", rec, 128);
    chk("both_rx_passive", err_state, 1);

    // Bus-off entry from tec=248.
    do_reset();
    for (int i = 0; i < 31; i++) begin tx_err = 1; cycle(); end
    idle();
    chk("tec_248", tec, 248);
    tx_err = 1; cycle(); idle();
    chk("bo_tec", tec, 256);
    chk("bo_state", err_state, 2);
    chk("bo_flag", bus_off, 1);
    chk("bo_warn", error_warning, 0);
    tx_success = 1; rx_err = 1; cycle(); idle();
    chk("bo_frozen_tec", tec, 256);
    chk("bo_frozen_rec", rec, 0);

    // Recovery with one dominant bit at bit 5 of sequence 3.
    recover_req = 1; cycle();
    chk("recovering", err_state, 3);
    got = 0; samples = -1;
    for (int k = 0; k < 3000 && !got; k++) begin
      sample_point = 1;
      rx_bit = (k == 3 * 11 + 4) ? 1'b0 : 1'b1;
      cycle();
      if (recovered) begin got = 1; samples = k + 1; end
    end
    idle();
    chk("recov_samples", samples, 128 * 11 + 5);
    chk("recov_tec", tec, 0);
    chk("recov_state", err_state, 0);

    // Abort recovery by dropping recover_req, then reset mid-recovery.
    for (int i = 0; i < 32; i++) begin tx_err = 1; cycle(); end
    idle();
    cycle();
    for (int k = 0; k < 50 * 11; k++) begin sample_point = 1; cycle(); end
    idle();
    chk("seq_50", recov_seq_cnt, 50);
    recover_req = 0; cycle();
    chk("drop_state", err_state, 2);
    chk("drop_seq", recov_seq_cnt, 0);
    recover_req = 1; cycle();
    for (int k = 0; k < 30; k++) begin sample_point = 1; cycle(); end
    do_reset();
    chk("rst_state", err_state, 0);

    // Randomized traffic with epoch-based error bias and occasional resets.
    for (int c = 0; c < 9000; c++) begin
      bit hi;
      hi = ((c / 1000) % 2) == 0;
      rst                = ($urandom_range(0, 2999) != 0);
      tx_err             = hi ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      tx_ack_passive_exc = ($urandom_range(0, 3) == 0);
      tx_success         = ($urandom_range(0, 5) == 0);
      rx_err             = ($urandom_range(0, 7) == 0);
      rx_prim_err        = hi ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
      rx_success         = ($urandom_range(0, 3) == 0);
      sample_point       = ($urandom_range(0, 3) != 0);
      rx_bit             = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 399) == 0) recover_req = ~recover_req;
      cycle();
    end
    rst = 1;
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
